// File: rtl/sha256_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_pkg : sequencer state type, block layout constants, SHA-256 round math
// Revision 1.0
// ----------------------------------------------------------------------------
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_FILL  = 3'd2,
    ST_PAD   = 3'd3,
    ST_START = 3'd4,
    ST_WAIT  = 3'd5,
    ST_DONE  = 3'd6
  } seq_state_t;

  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
  localparam logic [4:0]  LEN_HI_IDX  = 5'd14;
  localparam logic [4:0]  LEN_LO_IDX  = 5'd15;
  localparam logic [4:0]  BLOCK_WORDS = 5'd16;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] SHA256_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256 : iterative compression core, one round per cycle, chained hash state
// Revision 1.0
// ----------------------------------------------------------------------------
module sha256
  import sha256_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] block,
  output logic         finish,
  output logic [255:0] digest
);

  logic [31:0] hash  [8];
  logic [31:0] v     [8];
  logic [31:0] w     [16];
  logic [31:0] blk_w [16];
  logic [6:0]  round;
  logic        running;
  logic [31:0] wt;
  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    for (int i = 0; i < 16; i++) blk_w[i] = block[511-32*i -: 32];
  end

  // Rounds 0..15 take the message straight from the block; w is a sliding window of the last 16 schedule words.
  always_comb begin
    wt = (round < 7'd16) ? blk_w[round[3:0]] : ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    t1 = v[7] + bsig1(v[4]) + ch(v[4], v[5], v[6]) + SHA256_K[round[5:0]] + wt;
    t2 = bsig0(v[0]) + maj(v[0], v[1], v[2]);
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_digest
    assign digest[255-32*gi -: 32] = hash[gi];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        hash[i] <= SHA256_IV[255-32*i -: 32];
        v[i]    <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
      round   <= '0;
      running <= 1'b0;
      finish  <= 1'b0;
    end else if (start && !running) begin
      for (int i = 0; i < 8; i++) v[i] <= hash[i];
      round   <= '0;
      running <= 1'b1;
      finish  <= 1'b0;
    end else if (running) begin
      if (round == 7'd64) begin
        for (int i = 0; i < 8; i++) hash[i] <= hash[i] + v[i];
        running <= 1'b0;
        finish  <= 1'b1;
      end else begin
        v[0] <= t1 + t2;
        v[1] <= v[0];
        v[2] <= v[1];
        v[3] <= v[2];
        v[4] <= v[3] + t1;
        v[5] <= v[4];
        v[6] <= v[5];
        v[7] <= v[6];
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= wt;
        round <= round + 7'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha256_block_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_block_packer : 16-word block buffer with write index and 0x80 insertion
// Revision 1.0
// ----------------------------------------------------------------------------
module sha256_block_packer
  import sha256_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [31:0]  wr_data,
  input  logic [1:0]   wr_bytes,
  output logic [4:0]   index,
  output logic [511:0] block
);

  logic [31:0] words [16];
  logic [31:0] masked;

  // A partial word keeps its leading bytes, then the 0x80 marker, then zeros.
  always_comb begin
    case (wr_bytes)
      2'd1:    masked = {wr_data[31:24], 8'h80, 16'h0000};
      2'd2:    masked = {wr_data[31:16], 8'h80, 8'h00};
      2'd3:    masked = {wr_data[31:8], 8'h80};
      default: masked = wr_data;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index <= '0;
      for (int i = 0; i < 16; i++) words[i] <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (wr_en) begin
      words[index[3:0]] <= masked;
      index             <= index + 5'd1;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_block
    assign block[511-32*gi -: 32] = words[gi];
  end

endmodule
`default_nettype wire

// File: rtl/sha256_msg_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha256_msg_sequencer : streams a byte message into padded blocks and drives the core
// Revision 1.0
// ----------------------------------------------------------------------------
module sha256_msg_sequencer
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] byte_count;
  logic             pad_placed, len_pending, len_hi_done, msg_ended, core_reset_n;
  logic             pk_clear, pk_wr;
  logic [31:0]      pk_data;
  logic [1:0]       pk_bytes;
  logic [4:0]       pk_index;
  logic [511:0]     pk_block;
  logic             core_start, core_finish;
  logic [255:0]     core_digest;
  logic             last_partial, cnt_en, set_end, set_pad, set_hi;
  logic             set_pending, clr_pending, latch_digest, clr_flags;
  logic [2:0]       add_bytes;
  logic [63:0]      bit_len;

  assign last_partial = in_last && (in_bytes != 2'd0);
  assign add_bytes    = last_partial ? {1'b0, in_bytes} : 3'd4;
  assign bit_len      = {{(64-LEN_W){1'b0}}, byte_count} << 3;
  assign busy         = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    pk_clear     = 1'b0;
    pk_wr        = 1'b0;
    pk_data      = in_data;
    pk_bytes     = 2'd0;
    core_start   = 1'b0;
    cnt_en       = 1'b0;
    set_end      = 1'b0;
    set_pad      = 1'b0;
    set_hi       = 1'b0;
    set_pending  = 1'b0;
    clr_pending  = 1'b0;
    latch_digest = 1'b0;
    clr_flags    = 1'b0;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_CRST;
      ST_CRST: begin
        clr_flags = 1'b1;
        pk_clear  = 1'b1;
        state_d   = ST_FILL;
      end
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pk_wr    = 1'b1;
          pk_bytes = in_last ? in_bytes : 2'd0;
          cnt_en   = 1'b1;
          if (in_last) begin
            set_end = 1'b1;
            set_pad = last_partial;
            state_d = ST_PAD;
          end else if (pk_index == LEN_LO_IDX) begin
            state_d = ST_START;
          end
        end
      end
      ST_PAD: begin
        if (pk_index == BLOCK_WORDS) begin
          set_pending = 1'b1;
          state_d     = ST_START;
        end else begin
          pk_wr = 1'b1;
          if (!pad_placed) begin
            pk_data = PAD_WORD;
            set_pad = 1'b1;
          end else if (pk_index < LEN_HI_IDX) begin
            pk_data = '0;
          end else if (pk_index == LEN_HI_IDX) begin
            pk_data = bit_len[63:32];
            set_hi  = 1'b1;
          end else if (len_hi_done) begin
            pk_data = bit_len[31:0];
            state_d = ST_START;
          end else begin
            // Marker sits in word 14: word 15 is zero and the length spills into an extra block.
            pk_data = '0;
          end
        end
      end
      ST_START: begin
        core_start = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_finish) begin
          pk_clear = 1'b1;
          if (!msg_ended) begin
            state_d = ST_FILL;
          end else if (len_pending) begin
            clr_pending = 1'b1;
            state_d     = ST_PAD;
          end else begin
            latch_digest = 1'b1;
            state_d      = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      byte_count   <= '0;
      pad_placed   <= 1'b0;
      len_pending  <= 1'b0;
      len_hi_done  <= 1'b0;
      msg_ended    <= 1'b0;
      out_digest   <= '0;
      core_reset_n <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_reset_n <= (state_d != ST_CRST);
      if (clr_flags) begin
        byte_count  <= '0;
        pad_placed  <= 1'b0;
        len_pending <= 1'b0;
        len_hi_done <= 1'b0;
        msg_ended   <= 1'b0;
      end else begin
        if (cnt_en)      byte_count  <= byte_count + LEN_W'(add_bytes);
        if (set_end)     msg_ended   <= 1'b1;
        if (set_pad)     pad_placed  <= 1'b1;
        if (set_hi)      len_hi_done <= 1'b1;
        if (set_pending) len_pending <= 1'b1;
        if (clr_pending) len_pending <= 1'b0;
      end
      if (latch_digest) out_digest <= core_digest;
    end
  end

  sha256_block_packer u_packer (
    .clock    (clock),
    .reset    (reset),
    .clear    (pk_clear),
    .wr_en    (pk_wr),
    .wr_data  (pk_data),
    .wr_bytes (pk_bytes),
    .index    (pk_index),
    .block    (pk_block)
  );

  sha256 u_core (
    .clock   (clock),
    .reset_n (core_reset_n),
    .start   (core_start),
    .block   (pk_block),
    .finish  (core_finish),
    .digest  (core_digest)
  );

endmodule
`default_nettype wire
